// File: rtl/sig_pkg.sv
// Shared signal-controller package: pedestrian FSM state encodings and the
// lamp on/off levels also used by light1_2, light3 and control.
package sig_pkg;

  // Pedestrian crossing phases
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WALK  = 3'd2,
    ST_FLASH = 3'd3,
    ST_GAP   = 3'd4
  } ped_state_e;

  // Lamp drive levels
  localparam logic LAMP_ON  = 1'b1;
  localparam logic LAMP_OFF = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-high counter and a
// re-arm latch so that each qualified press produces exactly one pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 2,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  // The pulse fires on the edge that completes the DEBOUNCE_CYC-th synced-high cycle.
  localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_armed;
  logic [CNT_W-1:0] r_high_cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Combinational so the FSM acts on the same edge that qualifies the press
  assign press_pulse = r_armed & r_sync2 & (r_high_cnt == FIRE_AT);

  // Count consecutive synced-high cycles; disarm after firing until the button is seen low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_high_cnt <= '0;
      r_armed    <= 1'b1;
    end else if (!r_sync2) begin
      r_high_cnt <= '0;
      r_armed    <= 1'b1;
    end else if (press_pulse) begin
      r_high_cnt <= '0;
      r_armed    <= 1'b0;
    end else if (r_armed) begin
      r_high_cnt <= r_high_cnt + ONE;
    end
  end

endmodule

// File: rtl/ped_crossing_req.sv
// Pedestrian-crossing request front end: debounced button, held request to
// control, walk/flash/don't-walk lamp sequencing and a minimum gap between
// served requests. All outputs come straight from registers.
module ped_crossing_req
  import sig_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 2,
  parameter int WALK_CYC     = 10,
  parameter int FLASH_CYC    = 5,
  parameter int MIN_GAP_CYC  = 20,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic veh_safe,
  output logic ped_req,
  output logic ped_done,
  output logic req_pending,
  output logic walk,
  output logic dont_walk
);

  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYC);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYC);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ped_state_e       r_state;
  ped_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_cnt_last;

  logic r_ped_req;
  logic r_ped_done;
  logic r_req_pending;
  logic r_walk;
  logic r_dont_walk;

  logic w_ped_req_nxt;
  logic w_ped_done_nxt;
  logic w_req_pending_nxt;
  logic w_walk_nxt;
  logic w_dont_walk_nxt;

  logic w_press;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_btn_debounce (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .press_pulse (w_press)
  );

  // Phase ends on the edge where the counter reads 1 (also guards against 0)
  assign w_cnt_last = (r_cnt <= ONE);

  // Next-state, phase counter and next-output decode
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_ped_req_nxt     = r_ped_req;
    w_ped_done_nxt    = 1'b0;
    w_req_pending_nxt = r_req_pending;
    w_walk_nxt        = r_walk;
    w_dont_walk_nxt   = r_dont_walk;

    case (r_state)
      ST_IDLE: begin
        w_walk_nxt      = LAMP_OFF;
        w_dont_walk_nxt = LAMP_ON;
        // veh_safe on the same edge is deliberately not looked at here
        if (w_press) begin
          w_state_nxt       = ST_REQ;
          w_ped_req_nxt     = 1'b1;
          w_req_pending_nxt = 1'b1;
        end
      end

      ST_REQ: begin
        w_ped_req_nxt = 1'b1;
        if (veh_safe) begin
          w_state_nxt       = ST_WALK;
          w_cnt_nxt         = WALK_LD;
          w_req_pending_nxt = 1'b0;
          w_walk_nxt        = LAMP_ON;
          w_dont_walk_nxt   = LAMP_OFF;
        end
      end

      ST_WALK: begin
        // Losing veh_safe cuts steady walk short but still gives the full flash
        if (!veh_safe || w_cnt_last) begin
          w_state_nxt     = ST_FLASH;
          w_cnt_nxt       = FLASH_LD;
          w_walk_nxt      = LAMP_ON;
          w_dont_walk_nxt = LAMP_OFF;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end

      ST_FLASH: begin
        if (w_press) begin
          w_req_pending_nxt = 1'b1;
        end
        if (w_cnt_last) begin
          w_state_nxt     = ST_GAP;
          w_cnt_nxt       = GAP_LD;
          w_ped_done_nxt  = 1'b1;
          w_ped_req_nxt   = 1'b0;
          w_walk_nxt      = LAMP_OFF;
          w_dont_walk_nxt = LAMP_ON;
        end else begin
          w_cnt_nxt  = r_cnt - ONE;
          w_walk_nxt = ~r_walk;
        end
      end

      ST_GAP: begin
        if (w_press) begin
          w_req_pending_nxt = 1'b1;
        end
        if (w_cnt_last) begin
          // A press arriving on the final gap edge still counts as latched
          if (r_req_pending || w_press) begin
            w_state_nxt   = ST_REQ;
            w_ped_req_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end

      default: begin
        w_state_nxt       = ST_IDLE;
        w_cnt_nxt         = '0;
        w_ped_req_nxt     = 1'b0;
        w_req_pending_nxt = 1'b0;
        w_walk_nxt        = LAMP_OFF;
        w_dont_walk_nxt   = LAMP_ON;
      end
    endcase
  end

  // State, counter and output registers; reset forces the idle lamp picture at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ped_req     <= 1'b0;
      r_ped_done    <= 1'b0;
      r_req_pending <= 1'b0;
      r_walk        <= LAMP_OFF;
      r_dont_walk   <= LAMP_ON;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ped_req     <= w_ped_req_nxt;
      r_ped_done    <= w_ped_done_nxt;
      r_req_pending <= w_req_pending_nxt;
      r_walk        <= w_walk_nxt;
      r_dont_walk   <= w_dont_walk_nxt;
    end
  end

  assign ped_req     = r_ped_req;
  assign ped_done    = r_ped_done;
  assign req_pending = r_req_pending;
  assign walk        = r_walk;
  assign dont_walk   = r_dont_walk;

endmodule
